// File: rtl/radio_pkg.sv
// radio_pkg: shared definitions for the radio_link byte transceiver.
//   - TX / RX state encodings
//   - serial frame constants (data width, start/stop/idle line levels)
//   - frame_bits(): number of bit slots in one frame
// Optional feature macro: RADIO_PARITY_EN (adds an even-parity bit to each frame).
package radio_pkg;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic START_BIT       = 1'b0;
   localparam logic STOP_BIT        = 1'b1;
   localparam logic IDLE_LINE       = 1'b1;

`ifdef RADIO_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_t;

   // start + data + optional parity + stop
   function automatic int frame_bits(input bit parity_en);
      return parity_en ? FRAME_DATA_BITS + 3 : FRAME_DATA_BITS + 2;
   endfunction

endpackage

// File: rtl/radio_rx_deser.sv
// radio_rx_deser: receive side of radio_link.
//   Synchronizes rx_line, detects a start bit, samples each bit at mid-bit and
//   reports the assembled byte with a one-cycle byte_done or frame_err pulse at
//   the stop-bit sample.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   enable       low forces RX_IDLE
//   rx_line      asynchronous serial input (idles high)
//   rx_byte      assembled byte, valid while byte_done is high
//   byte_done    one-cycle pulse: good frame received
//   frame_err    one-cycle pulse: bad stop bit (or bad parity with RADIO_PARITY_EN)
// Requires SYNC_STAGES >= 2, BIT_CYCLES even and >= 4.
//
// state     | meaning
// RX_IDLE   | waiting for a synchronized high->low edge
// RX_START  | half a bit in; resample to reject glitches
// RX_DATA   | sampling 8 data bits, LSB first
// RX_PARITY | sampling the even-parity bit (RADIO_PARITY_EN only)
// RX_STOP   | sampling the stop bit, then back to idle
module radio_rx_deser import radio_pkg::*; #(
   parameter int BIT_CYCLES  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       rx_line,
   output logic [7:0] rx_byte,
   output logic       byte_done,
   output logic       frame_err
);

   localparam int             TW          = $clog2(BIT_CYCLES);
   localparam logic [TW-1:0]  BIT_RELOAD  = TW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0]  HALF_RELOAD = TW'(BIT_CYCLES / 2 - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s, rx_prev, rx_fall, rx_tick, stop_sample, parity_ok;
   logic [TW-1:0]          rx_timer;
   logic [2:0]             rx_bits_left;
   logic [7:0]             rx_shift;
   rx_state_t              rx_state, rx_state_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync    <= '1;
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], rx_line};
         rx_prev <= rx_s;
      end
   end

   assign rx_s    = sync[SYNC_STAGES-1];
   assign rx_fall = rx_prev & ~rx_s;
   assign rx_tick = (rx_state != RX_IDLE) && (rx_timer == '0);

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) rx_state <= RX_IDLE;
      else                   rx_state <= rx_state_nxt;
   end

   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:   if (rx_fall) rx_state_nxt = RX_START;
         RX_START:  if (rx_tick) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:
            if (rx_tick && rx_bits_left == '0) begin
`ifdef RADIO_PARITY_EN
               rx_state_nxt = RX_PARITY;
`else
               rx_state_nxt = RX_STOP;
`endif
            end
         RX_PARITY: if (rx_tick) rx_state_nxt = RX_STOP;
         RX_STOP:   if (rx_tick) rx_state_nxt = RX_IDLE;
         default:   rx_state_nxt = RX_IDLE;
      endcase
   end

`ifdef RADIO_PARITY_EN
   logic rx_par_bit;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         rx_timer     <= '0;
         rx_bits_left <= '0;
         rx_shift     <= '0;
`ifdef RADIO_PARITY_EN
         rx_par_bit   <= 1'b0;
`endif
      end else if (rx_state == RX_IDLE) begin
         if (rx_fall) rx_timer <= HALF_RELOAD;
      end else if (rx_tick) begin
         rx_timer <= BIT_RELOAD;
         case (rx_state)
            RX_START: rx_bits_left <= 3'(FRAME_DATA_BITS - 1);
            RX_DATA: begin
               rx_shift     <= {rx_s, rx_shift[7:1]};
               rx_bits_left <= rx_bits_left - 3'd1;
            end
`ifdef RADIO_PARITY_EN
            RX_PARITY: rx_par_bit <= rx_s;
`endif
            default: ;
         endcase
      end else begin
         rx_timer <= rx_timer - 1'b1;
      end
   end

`ifdef RADIO_PARITY_EN
   assign parity_ok = (rx_par_bit == ^rx_shift);
`else
   assign parity_ok = 1'b1;
`endif

   assign stop_sample = (rx_state == RX_STOP) && rx_tick;
   assign byte_done   = stop_sample & (rx_s == STOP_BIT) & parity_ok;
   assign frame_err   = stop_sample & ~((rx_s == STOP_BIT) & parity_ok);
   assign rx_byte     = rx_shift;

endmodule

// File: rtl/radio_link.sv
// radio_link: byte-level asynchronous-serial radio transceiver.
//   TX FSM serializes one byte per radio_send onto tx_line; RX bytes land in a
//   one-byte holding buffer read back over the shared radio_data bus.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   radio_enable    low forces idle (sticky error flags hold)
//   radio_send      TX request, radio_data sampled the same cycle
//   radio_receive   read request (level); block drives radio_data while reading
//   radio_data      shared 8-bit bus, released (z) unless reading
//   radio_busy      TX in flight, or read pending with empty buffer
//   tx_line         serial out, idles high
//   rx_line         serial in, asynchronous
//   rx_valid        buffer holds an unread byte
//   rx_overrun      sticky: byte dropped, buffer full
//   rx_frame_err    sticky: stop-bit (or parity) failure
// Optional feature macro: RADIO_PARITY_EN (even parity bit between data and stop).
//
// state     | meaning
// TX_IDLE   | line high, ready to accept radio_send
// TX_START  | driving the start bit
// TX_DATA   | driving 8 data bits, LSB first
// TX_PARITY | driving the even-parity bit (RADIO_PARITY_EN only)
// TX_STOP   | driving the stop bit
module radio_link import radio_pkg::*; #(
   parameter int BIT_CYCLES  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       radio_enable,
   input  logic       radio_send,
   input  logic       radio_receive,
   inout  wire  [7:0] radio_data,
   output logic       radio_busy,
   output logic       tx_line,
   input  logic       rx_line,
   output logic       rx_valid,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int            TW         = $clog2(BIT_CYCLES);
   localparam logic [TW-1:0] BIT_RELOAD = TW'(BIT_CYCLES - 1);
   localparam int            FB         = frame_bits(PARITY_EN);
   localparam logic [3:0]    FB_LAST    = 4'(FB - 1);
   // bits_left value while the last data bit is on the line
   localparam logic [3:0]    LAST_DATA  = 4'(FB - 1 - FRAME_DATA_BITS);

   tx_state_t     tx_state, tx_state_nxt;
   logic [TW-1:0] tx_timer;
   logic [3:0]    tx_bits_left;
   logic [7:0]    tx_shift;
   logic          tx_active, tx_tick, tx_accept;

   assign tx_active = (tx_state != TX_IDLE);
   assign tx_tick   = tx_active && (tx_timer == '0);
   assign tx_accept = radio_enable & radio_send & ~tx_active;

   always_ff @(posedge clk) begin
      if (!rst_n || !radio_enable) tx_state <= TX_IDLE;
      else                         tx_state <= tx_state_nxt;
   end

   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         TX_IDLE:   if (tx_accept) tx_state_nxt = TX_START;
         TX_START:  if (tx_tick) tx_state_nxt = TX_DATA;
         TX_DATA:
            if (tx_tick && tx_bits_left == LAST_DATA) begin
`ifdef RADIO_PARITY_EN
               tx_state_nxt = TX_PARITY;
`else
               tx_state_nxt = TX_STOP;
`endif
            end
         TX_PARITY: if (tx_tick) tx_state_nxt = TX_STOP;
         TX_STOP:   if (tx_tick) tx_state_nxt = TX_IDLE;
         default:   tx_state_nxt = TX_IDLE;
      endcase
   end

`ifdef RADIO_PARITY_EN
   logic tx_par;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n || !radio_enable) begin
         tx_timer     <= '0;
         tx_bits_left <= '0;
         tx_shift     <= '0;
`ifdef RADIO_PARITY_EN
         tx_par       <= 1'b0;
`endif
      end else if (tx_accept) begin
         tx_timer     <= BIT_RELOAD;
         tx_bits_left <= FB_LAST;
         tx_shift     <= radio_data;
`ifdef RADIO_PARITY_EN
         tx_par       <= ^radio_data;
`endif
      end else if (tx_active) begin
         if (tx_tick) begin
            tx_timer     <= BIT_RELOAD;
            tx_bits_left <= tx_bits_left - 4'd1;
            if (tx_state == TX_DATA) tx_shift <= {1'b0, tx_shift[7:1]};
         end else begin
            tx_timer <= tx_timer - 1'b1;
         end
      end
   end

   always_comb begin
      tx_line = IDLE_LINE;
      case (tx_state)
         TX_START: tx_line = START_BIT;
         TX_DATA:  tx_line = tx_shift[0];
`ifdef RADIO_PARITY_EN
         TX_PARITY: tx_line = tx_par;
`endif
         TX_STOP:  tx_line = STOP_BIT;
         default:  tx_line = IDLE_LINE;
      endcase
   end

   logic [7:0] rx_byte, rx_buf;
   logic       byte_done, frame_err, bus_drive, drive_q, read_done, valid_kept;

   radio_rx_deser #(
      .BIT_CYCLES  (BIT_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (radio_enable),
      .rx_line   (rx_line),
      .rx_byte   (rx_byte),
      .byte_done (byte_done),
      .frame_err (frame_err)
   );

   assign bus_drive  = radio_enable & radio_receive & ~radio_send & rx_valid;
   assign radio_data = bus_drive ? rx_buf : 8'bz;
   // a read completes when radio_receive drops after a cycle of driving the bus
   assign read_done  = drive_q & ~radio_receive;
   // clear first, then load: a byte landing on the clear cycle is not an overrun
   assign valid_kept = rx_valid & ~read_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_valid     <= 1'b0;
         rx_buf       <= '0;
         drive_q      <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else if (!radio_enable) begin
         rx_valid <= 1'b0;
         drive_q  <= 1'b0;
      end else begin
         drive_q  <= bus_drive;
         rx_valid <= valid_kept;
         if (byte_done) begin
            if (valid_kept) begin
               rx_overrun <= 1'b1;
            end else begin
               rx_buf   <= rx_byte;
               rx_valid <= 1'b1;
            end
         end
         if (frame_err) rx_frame_err <= 1'b1;
      end
   end

   assign radio_busy = tx_active | (radio_receive & ~rx_valid);

endmodule

// File: tb/tb_radio_link.sv
module tb_radio_link;

   localparam int BC = 4;
`ifdef RADIO_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       radio_enable = 1'b0;
   logic       radio_send = 1'b0;
   logic       radio_receive = 1'b0;
   logic       rx_man = 1'b1;
   logic       loop_en = 1'b1;
   logic       tb_drv = 1'b0;
   logic [7:0] tb_data = 8'h00;

   wire  [7:0] radio_data;
   wire        radio_busy, tx_line, rx_line, rx_valid, rx_overrun, rx_frame_err;

   assign radio_data = tb_drv ? tb_data : 8'bz;
   assign rx_line    = loop_en ? tx_line : rx_man;

   // released bus reads as all ones
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (radio_data[g]);
   end

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   radio_link #(.BIT_CYCLES(BC), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .radio_enable  (radio_enable),
      .radio_send    (radio_send),
      .radio_receive (radio_receive),
      .radio_data    (radio_data),
      .radio_busy    (radio_busy),
      .tx_line       (tx_line),
      .rx_line       (rx_line),
      .rx_valid      (rx_valid),
      .rx_overrun    (rx_overrun),
      .rx_frame_err  (rx_frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // expected line level for bit slot i of a frame carrying d
   function automatic logic fbit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (NBITS == 11 && i == 9) return ^d;
      return 1'b1;
   endfunction

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      radio_send = 1'b1;
      tb_drv     = 1'b1;
      tb_data    = d;
      @(negedge clk);
      radio_send = 1'b0;
      tb_drv     = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_stop, input logic bad_par);
      for (int i = 0; i < NBITS; i++) begin
         rx_man = fbit(d, i);
         if (i == NBITS - 1 && bad_stop) rx_man = 1'b0;
         if (NBITS == 11 && i == 9 && bad_par) rx_man = ~rx_man;
         repeat (BC) @(negedge clk);
      end
      rx_man = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (radio_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, radio_busy, 1'b0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!rx_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, rx_valid, 1'b1);
   endtask

   // full read: receive high for one cycle, then drop and confirm the clear
   task automatic read_byte(input string tag);
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      @(negedge clk);
      radio_receive = 1'b1;
      @(negedge clk);
      chk({tag, "_data"}, radio_data, e);
      chk({tag, "_busy"}, radio_busy, 1'b0);
      radio_receive = 1'b0;
      chk({tag, "_held"}, rx_valid, 1'b1);
      @(negedge clk);
      chk({tag, "_clr"}, rx_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         n, bad;
      logic [7:0] e;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tx_line", tx_line, 1'b1);
      chk("rst_busy", radio_busy, 1'b0);
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_overrun", rx_overrun, 1'b0);
      chk("rst_frame_err", rx_frame_err, 1'b0);
      chk("rst_bus", radio_data, 8'hFF);
      rst_n = 1'b1;
      radio_enable = 1'b1;
      repeat (3) @(negedge clk);

      // loopback 8'hA5: frame timing and line pattern
      exp_q.push_back(8'hA5);
      send(8'hA5);
      chk("start_bit", tx_line, 1'b0);
      chk("busy_rise", radio_busy, 1'b1);
      n = 0;
      bad = 0;
      while (radio_busy && n < 200) begin
         if (tx_line !== fbit(8'hA5, n / BC)) bad++;
         n++;
         @(negedge clk);
      end
      chk("busy_len", n, NBITS * BC);
      chk("tx_pattern_errs", bad, 0);
      wait_valid("a5_valid");
      read_byte("a5");

      // second send during an active frame is dropped
      exp_q.push_back(8'h96);
      send(8'h96);
      repeat (10) @(negedge clk);
      send(8'h3C);
      wait_idle("ign_idle");
      wait_valid("ign_valid");
      read_byte("ign");
      repeat (60) @(negedge clk);
      chk("ign_no_second", rx_valid, 1'b0);

      // two frames, no read: first byte kept, overrun flagged
      exp_q.push_back(8'h11);
      send(8'h11);
      wait_idle("ovr_idle1");
      send(8'h22);
      wait_idle("ovr_idle2");
      repeat (20) @(negedge clk);
      chk("ovr_flag", rx_overrun, 1'b1);
      chk("ovr_valid", rx_valid, 1'b1);
      read_byte("ovr");

      // glitch on the line is rejected silently
      loop_en = 1'b0;
      rx_man = 1'b1;
      repeat (5) @(negedge clk);
      rx_man = 1'b0;
      repeat (2) @(negedge clk);
      rx_man = 1'b1;
      repeat (10) @(negedge clk);
      chk("glitch_no_err", rx_frame_err, 1'b0);
      chk("glitch_no_valid", rx_valid, 1'b0);

      // read pending on an empty buffer, then a byte arrives
      radio_receive = 1'b1;
      @(negedge clk);
      chk("pend_busy", radio_busy, 1'b1);
      chk("pend_bus_released", radio_data, 8'hFF);
      exp_q.push_back(8'h5F);
      send_frame(8'h5F, 1'b0, 1'b0);
      wait_valid("pend_valid");
      @(negedge clk);
      e = exp_q.pop_front();
      chk("pend_data", radio_data, e);
      chk("pend_busy_fall", radio_busy, 1'b0);
      radio_receive = 1'b0;
      @(negedge clk);
      chk("pend_clr", rx_valid, 1'b0);

      // bad stop bit
      repeat (5) @(negedge clk);
      send_frame(8'h77, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      chk("stop_no_valid", rx_valid, 1'b0);
      chk("stop_frame_err", rx_frame_err, 1'b1);

      // disable holds sticky flags
      radio_enable = 1'b0;
      @(negedge clk);
      chk("dis_frame_err", rx_frame_err, 1'b1);
      chk("dis_overrun", rx_overrun, 1'b1);
      chk("dis_tx_line", tx_line, 1'b1);
      radio_enable = 1'b1;
      @(negedge clk);

      // reset in the middle of a transmission
      loop_en = 1'b1;
      send(8'hC3);
      repeat (14) @(negedge clk);
      chk("mid_busy", radio_busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx_line", tx_line, 1'b1);
      chk("mid_rst_busy", radio_busy, 1'b0);
      chk("mid_rst_overrun", rx_overrun, 1'b0);
      chk("mid_rst_frame_err", rx_frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

`ifdef RADIO_PARITY_EN
      // corrupted parity bit
      loop_en = 1'b0;
      rx_man = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      chk("par_frame_err", rx_frame_err, 1'b1);
      chk("par_no_valid", rx_valid, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
